seq_div8: RTL



---
 rtl/div_pkg.sv | 14 +
 rtl/cs_sub9.sv | 32 +++
 rtl/seq_div8.sv | 101 ++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: default sizes,
// FSM state encoding and the quotient reported for a zero divisor.
package div_pkg;
  localparam int DIV_WIDTH = 8;
  localparam int DIV_CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = '1;
endpackage

// File: rtl/cs_sub9.sv
// 9-bit carry-select trial subtractor (a - b as a + ~b + 1): CLA low nibble,
// upper five bits precomputed for both carries and picked by the nibble carry.
module cs_sub9 (
  input  logic [8:0] a,
  input  logic [8:0] b,
  output logic [8:0] diff,
  output logic       borrow
);
  logic [8:0] nb;
  logic [3:0] g, p;
  logic [4:0] c;
  logic [5:0] hi0, hi1, hi;

  assign nb = ~b;
  assign g  = a[3:0] & nb[3:0];
  assign p  = a[3:0] ^ nb[3:0];

  assign c[0] = 1'b1;
  assign c[1] = g[0] | p[0];
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0]);

  assign hi0 = {1'b0, a[8:4]} + {1'b0, nb[8:4]};
  assign hi1 = {1'b0, a[8:4]} + {1'b0, nb[8:4]} + 6'd1;
  assign hi  = c[4] ? hi1 : hi0;

  assign diff   = {hi[4:0], p ^ c[3:0]};
  // No carry out of the top bit means a < b.
  assign borrow = ~hi[5];
endmodule

// File: rtl/seq_div8.sv
// Unsigned restoring divider producing one quotient bit per clock, with a
// start/ready/done handshake and a divide-by-zero shortcut.
module seq_div8
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] d, q, r;
  logic [WIDTH:0]   rs, t;
  logic             brw;
  logic             accept, zero_div, last, running;
  logic [WIDTH-1:0] q_step, r_step;

  assign ready    = (state != S_RUN);
  assign done     = (state == S_DONE);
  assign running  = (state == S_RUN);
  assign accept   = ready & start;
  assign zero_div = (divisor == '0);
  assign last     = (cnt == CNT_W'(WIDTH - 1));

  // Shift the next dividend bit into the partial remainder and try D.
  assign rs = {r, q[WIDTH-1]};

  cs_sub9 u_sub (
    .a      (rs),
    .b      ({1'b0, d}),
    .diff   (t),
    .borrow (brw)
  );

  // A negative trial difference restores Rs; the remainder always fits WIDTH bits.
  assign r_step = t[WIDTH] ? rs[WIDTH-1:0] : t[WIDTH-1:0];
  assign q_step = {q[WIDTH-2:0], ~brw};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start)                 state_nx = zero_div ? S_DONE : S_RUN;
        else if (state == S_DONE)  state_nx = S_IDLE;
      end
      S_RUN: begin
        if (last) state_nx = S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          cnt <= '0;
    else if (accept)  cnt <= '0;
    else if (running) cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      d <= divisor;
      q <= dividend;
      r <= '0;
    end else if (running) begin
      q <= q_step;
      r <= r_step;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      div_by_zero <= zero_div;
      if (zero_div) begin
        quotient  <= WIDTH'(DBZ_QUOTIENT);
        remainder <= dividend;
      end
    end else if (running && last) begin
      quotient  <= q_step;
      remainder <= r_step;
    end
  end
endmodule
